// File: rtl/otter_demux_pkg.sv
// Shared types and helpers for the OTTER result demux: default entry layout,
// statistics width and the destination one-hot decoder.
package otter_demux_pkg;

  localparam int STAT_W    = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;
  localparam int MAX_DEST  = 8;
  localparam int MAX_SEL_W = 3;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEL_W = 2;

  typedef struct packed {
    logic [DEF_SEL_W-1:0] sel;
    logic [DEF_WIDTH-1:0] data;
  } demux_entry_t;

  // Selects at or beyond num_dest decode to all zeros so they never raise a valid.
  function automatic logic [MAX_DEST-1:0] onehot_dec(input logic [MAX_SEL_W-1:0] sel,
                                                     input int num_dest);
    logic [MAX_DEST-1:0] code;
    code = {MAX_DEST{1'b0}};
    if (int'(sel) < num_dest) begin
      code[sel] = 1'b1;
    end else begin
      code = {MAX_DEST{1'b0}};
    end
    return code;
  endfunction

endpackage

// File: rtl/otter_result_fifo.sv
// In-order sync FIFO of demux entries. Pointers carry one extra MSB so full and
// empty are told apart without a counter; ready is the registered not-full flag.
module otter_result_fifo
  import otter_demux_pkg::*;
#(
  parameter type entry_t = demux_entry_t,
  parameter int  DEPTH   = 2
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   push,
  input  entry_t wr_entry,
  input  logic   pop,
  output entry_t head,
  output logic   empty,
  output logic   ready
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem_r [DEPTH];
  logic [PTR_W:0]   wr_ptr_r;
  logic [PTR_W:0]   rd_ptr_r;
  logic [PTR_W:0]   wr_ptr_s;
  logic [PTR_W:0]   rd_ptr_s;
  logic             full_s;
  logic             full_next_s;
  logic             do_push_s;
  logic             do_pop_s;

  // Next-pointer and status computation.
  always_comb begin
    empty       = (wr_ptr_r == rd_ptr_r);
    full_s      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                  (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    do_push_s   = push & ~full_s;
    do_pop_s    = pop & ~empty;
    wr_ptr_s    = wr_ptr_r + {{PTR_W{1'b0}}, do_push_s};
    rd_ptr_s    = rd_ptr_r + {{PTR_W{1'b0}}, do_pop_s};
    full_next_s = (wr_ptr_s[PTR_W] != rd_ptr_s[PTR_W]) &&
                  (wr_ptr_s[PTR_W-1:0] == rd_ptr_s[PTR_W-1:0]);
    head        = mem_r[rd_ptr_r[PTR_W-1:0]];
  end

  // Pointer and ready state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_r <= {(PTR_W+1){1'b0}};
      rd_ptr_r <= {(PTR_W+1){1'b0}};
      ready    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      ready    <= ~full_next_s;
    end
  end

  // Storage write.
  always_ff @(posedge CLK) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[PTR_W-1:0]] <= wr_entry;
    end
  end

endmodule

// File: rtl/otter_result_demux.sv
// Steers buffered result words to one of NUM_DEST consumers, strictly in order.
// Optional per-destination counters under OTTER_RESULT_DEMUX_STATS_EN.
module otter_result_demux
  import otter_demux_pkg::*;
#(
  parameter int  WIDTH    = 32,
  parameter int  NUM_DEST = 4,
  parameter int  DEPTH    = 2,
  localparam int SEL_W    = $clog2(NUM_DEST)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [NUM_DEST-1:0] out_valid,
  input  logic [NUM_DEST-1:0] out_ready,
`ifdef OTTER_RESULT_DEMUX_STATS_EN
  output logic [NUM_DEST-1:0][STAT_W-1:0] stat_cnt,
  output logic [STAT_W-1:0]   stat_drop,
`endif
  output logic                sel_err
);

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t                wr_entry_s;
  entry_t                head_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  head_oob_s;
  logic [MAX_SEL_W-1:0]  head_sel_s;
  logic [NUM_DEST-1:0]   head_onehot_s;
  logic [NUM_DEST-1:0]   deliver_s;
  logic [WIDTH-1:0]      last_data_r;

  // Producer side: ready is registered, so push never depends on out_ready.
  always_comb begin
    wr_entry_s.sel  = in_sel;
    wr_entry_s.data = in_data;
    push_s          = in_valid & in_ready;
  end

  otter_result_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (push_s),
    .wr_entry (wr_entry_s),
    .pop      (pop_s),
    .head     (head_s),
    .empty    (empty_s),
    .ready    (in_ready)
  );

  // Head decode; an out-of-range select raises no valid and drops itself.
  always_comb begin
    head_sel_s    = MAX_SEL_W'(head_s.sel);
    head_onehot_s = NUM_DEST'(onehot_dec(head_sel_s, NUM_DEST));
    if (empty_s) begin
      out_valid  = {NUM_DEST{1'b0}};
      head_oob_s = 1'b0;
      out_data   = last_data_r;
    end else begin
      out_valid  = head_onehot_s;
      head_oob_s = (head_onehot_s == {NUM_DEST{1'b0}});
      out_data   = head_s.data;
    end
    deliver_s = out_valid & out_ready;
    pop_s     = head_oob_s | (|deliver_s);
    sel_err   = head_oob_s;
  end

  // Remembers the last presented word so out_data holds while empty.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_data_r <= {WIDTH{1'b0}};
    end else if (!empty_s) begin
      last_data_r <= head_s.data;
    end else begin
      last_data_r <= last_data_r;
    end
  end

`ifdef OTTER_RESULT_DEMUX_STATS_EN
  // Saturating delivery and drop counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_cnt  <= {(NUM_DEST*STAT_W){1'b0}};
      stat_drop <= {STAT_W{1'b0}};
    end else begin
      for (int d = 0; d < NUM_DEST; d++) begin
        if (deliver_s[d] && (stat_cnt[d] != STAT_MAX)) begin
          stat_cnt[d] <= stat_cnt[d] + STAT_W'(1);
        end
      end
      if (head_oob_s && (stat_drop != STAT_MAX)) begin
        stat_drop <= stat_drop + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_otter_result_demux.sv
// Self-checking bench for otter_result_demux: directed scenarios plus random
// traffic against a queue-based reference model; a NUM_DEST=3 copy covers drops.
module tb_otter_result_demux;

  localparam int DEPTH = 2;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] data;
  } ent_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        sel_err;

  logic [31:0] in_data3;
  logic [1:0]  in_sel3;
  logic        in_valid3;
  logic        in_ready3;
  logic [31:0] out_data3;
  logic [2:0]  out_valid3;
  logic [2:0]  out_ready3;
  logic        sel_err3;

`ifdef OTTER_RESULT_DEMUX_STATS_EN
  logic [3:0][15:0] stat_cnt;
  logic [15:0]      stat_drop;
  logic [2:0][15:0] stat_cnt3;
  logic [15:0]      stat_drop3;
`endif

  int          total = 0;
  int          bad   = 0;
  ent_t        q[$];
  bit          m_ready = 1'b0;
  logic [31:0] m_last  = 32'h0;

  always #5 CLK = ~CLK;

  otter_result_demux #(.WIDTH(32), .NUM_DEST(4), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef OTTER_RESULT_DEMUX_STATS_EN
    .stat_cnt  (stat_cnt),
    .stat_drop (stat_drop),
`endif
    .sel_err   (sel_err)
  );

  otter_result_demux #(.WIDTH(32), .NUM_DEST(3), .DEPTH(DEPTH)) dut3 (
    .CLK       (CLK),
    .RST       (RST),
    .in_data   (in_data3),
    .in_sel    (in_sel3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
`ifdef OTTER_RESULT_DEMUX_STATS_EN
    .stat_cnt  (stat_cnt3),
    .stat_drop (stat_drop3),
`endif
    .sel_err   (sel_err3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare DUT outputs with the model's view of the FIFO head.
  task automatic compare_model();
    logic [3:0]  exp_v;
    logic [31:0] exp_d;
    exp_v = 4'b0000;
    exp_d = m_last;
    if (q.size() != 0) begin
      exp_v = 4'b0001 << q[0].sel;
      exp_d = q[0].data;
    end
    check("out_valid", out_valid, exp_v);
    check("out_data", out_data, exp_d);
    check("in_ready", in_ready, m_ready);
    check("sel_err", sel_err, 1'b0);
    if (q.size() != 0) m_last = q[0].data;
  endtask

  // One clock: inputs are already applied; advance the model and check at negedge.
  task automatic tick(output bit pushed);
    bit   pop;
    ent_t e;
    pushed = in_valid && m_ready;
    pop    = (q.size() != 0) && out_ready[q[0].sel];
    e.sel  = in_sel;
    e.data = in_data;
    @(posedge CLK);
    if (pop) e = q.pop_front();
    if (pushed) begin
      e.sel  = in_sel;
      e.data = in_data;
      q.push_back(e);
    end
    m_ready = (q.size() < DEPTH);
    @(negedge CLK);
    compare_model();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    check("rst_valid_async", out_valid, 4'b0000);
    check("rst_ready", in_ready, 1'b0);
    check("rst_data", out_data, 32'h0);
    check("rst_sel_err", sel_err, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    check("rst_ready_held", in_ready, 1'b0);
    RST = 1'b0;
    q.delete();
    m_last  = 32'h0;
    m_ready = 1'b0;
    @(posedge CLK);
    m_ready = 1'b1;
    @(negedge CLK);
    compare_model();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          pushed;
    int          k;
    int          delivered;
    logic [31:0] w [3];

    in_valid  = 1'b0; in_sel  = 2'd0; in_data  = 32'h0; out_ready  = 4'b0000;
    in_valid3 = 1'b0; in_sel3 = 2'd0; in_data3 = 32'h0; out_ready3 = 3'b000;
    @(negedge CLK);
    do_reset();

    // Single word to dest 2, visible one cycle after the push.
    in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hCAFE0001; out_ready = 4'b0100;
    tick(pushed);
    in_valid = 1'b0;
    check("t1_valid", out_valid, 4'b0100);
    check("t1_data", out_data, 32'hCAFE0001);
    check("t1_ready", in_ready, 1'b1);
    tick(pushed);
    check("t1_popped", out_valid, 4'b0000);

    // Backpressure: only DEPTH words fit; third word held then drained in order.
    w[0] = 32'hA0A0_0000; w[1] = 32'hA1A1_1111; w[2] = 32'hA2A2_2222;
    out_ready = 4'b0000;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_sel = 2'(k); in_data = w[k];
      tick(pushed);
      if (pushed) k++;
    end
    check("t2_full", in_ready, 1'b0);
    check("t2_accepted", k, 2);
    out_ready = 4'hF;
    for (int c = 0; c < 12 && (k < 3 || out_valid != 4'b0000); c++) begin
      if (k < 3) begin
        in_valid = 1'b1; in_sel = 2'(k); in_data = w[k];
      end else begin
        in_valid = 1'b0;
      end
      tick(pushed);
      if (pushed) k++;
    end
    in_valid = 1'b0;
    check("t2_all_accepted", k, 3);
    check("t2_drained", out_valid, 4'b0000);

    // Head-of-line blocking: a stalled dest 0 hides the dest 1 word behind it.
    out_ready = 4'b0010;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hB000_0000;
    tick(pushed);
    in_sel = 2'd1; in_data = 32'hB111_1111;
    tick(pushed);
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick(pushed);
      check("t3_blocked", out_valid, 4'b0001);
    end
    out_ready = 4'b0011;
    tick(pushed);
    check("t3_next_valid", out_valid, 4'b0010);
    check("t3_next_data", out_data, 32'hB111_1111);
    tick(pushed);
    check("t3_empty", out_valid, 4'b0000);

    // Streaming at one word per cycle with rotating destinations.
    out_ready = 4'hF;
    delivered = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_sel = 2'(i % 4); in_data = 32'h5000_0000 + 32'(i);
      tick(pushed);
      check("t4_ready", in_ready, 1'b1);
      if (out_valid != 4'b0000) delivered++;
    end
    in_valid = 1'b0;
    tick(pushed);
    if (out_valid != 4'b0000) delivered++;
    check("t4_delivered", delivered, 16);
    check("t4_end_empty", out_valid, 4'b0000);

    // Reset between clock edges with two words buffered.
    out_ready = 4'b0000;
    in_valid = 1'b1; in_sel = 2'd3; in_data = 32'hD333_3333;
    tick(pushed);
    in_sel = 2'd1; in_data = 32'hD111_1111;
    tick(pushed);
    in_valid = 1'b0;
    check("t5_pre_reset", out_valid, 4'b1000);
    #2;
    do_reset();
    check("t5_post_ready", in_ready, 1'b1);

    // Random traffic against the queue model.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = $urandom;
      out_ready = 4'($urandom_range(0, 15));
      tick(pushed);
    end
    in_valid = 1'b0;

    // NUM_DEST=3: select 3 is discarded with a one-cycle sel_err.
    check("t6_ready0", in_ready3, 1'b1);
    out_ready3 = 3'b111;
    in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 32'hEEEE_0003;
    @(posedge CLK); @(negedge CLK);
    check("t6_drop_valid", out_valid3, 3'b000);
    check("t6_drop_err", sel_err3, 1'b1);
    check("t6_drop_data", out_data3, 32'hEEEE_0003);
    in_sel3 = 2'd1; in_data3 = 32'hEEEE_0001;
    @(posedge CLK); @(negedge CLK);
    in_valid3 = 1'b0;
    check("t6_next_valid", out_valid3, 3'b010);
    check("t6_next_data", out_data3, 32'hEEEE_0001);
    check("t6_err_cleared", sel_err3, 1'b0);
    check("t6_ready1", in_ready3, 1'b1);
    @(posedge CLK); @(negedge CLK);
    check("t6_empty", out_valid3, 3'b000);
    check("t6_err_quiet", sel_err3, 1'b0);
`ifdef OTTER_RESULT_DEMUX_STATS_EN
    check("t6_stat_drop", stat_drop3, 16'd1);
    check("t6_stat_cnt1", stat_cnt3[1], 16'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
